dc_router_nch: RTL

- Parametrised successor to the fixed three-accelerator data/control router.
- Moves data between a single-port RAM and NCH accelerator channels (FFT, FIR, IIR, ...), each with a to-accelerator FIFO and a from-accelerator FIFO.
- Per-channel address generation and read/write counting; round-robin arbitration for the one RAM port per cycle.
- Pulses acc_done when every selected channel has finished both read and write phases.

---
 rtl/dc_router_pkg.sv | 19 +
 rtl/dc_rr_arbiter.sv | 29 ++
 rtl/dc_router_nch.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/dc_router_pkg.sv
// Shared types and constants for the N-channel data/control router.
package dc_router_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } state_t;

  localparam int unsigned DEF_NCH    = 3;
  localparam int unsigned DEF_DATA_W = 128;
  localparam int unsigned DEF_ADDR_W = 32;
  localparam int unsigned RAM_RD_LAT = 1;

  function automatic int unsigned wrap_inc(input int unsigned i, input int unsigned n);
    return (i + 1 >= n) ? 0 : i + 1;
  endfunction

endpackage

// File: rtl/dc_rr_arbiter.sv
// N-way round-robin arbiter: the first requester at or after ptr wins.
module dc_rr_arbiter #(
  parameter int unsigned N = 3
) (
  input  logic [N-1:0]                      req,
  input  logic [((N > 1) ? $clog2(N) : 1)-1:0] ptr,
  output logic [N-1:0]                      grant,
  output logic [((N > 1) ? $clog2(N) : 1)-1:0] grant_idx,
  output logic                              grant_valid
);
  localparam int unsigned IDX_W = (N > 1) ? $clog2(N) : 1;

  always_comb begin
    int unsigned c;
    grant       = '0;
    grant_idx   = '0;
    grant_valid = 1'b0;
    c           = 0;
    for (int unsigned k = 0; k < N; k++) begin
      c = (32'(ptr) + k) % N;
      if (!grant_valid && req[c]) begin
        grant[c]    = 1'b1;
        grant_idx   = IDX_W'(c);
        grant_valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/dc_router_nch.sv
// Moves data between one single-port RAM and NCH accelerator FIFO pairs,
// one RAM operation per cycle under round-robin arbitration.
module dc_router_nch
  import dc_router_pkg::*;
#(
  parameter int unsigned NCH    = DEF_NCH,
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned ADDR_W = DEF_ADDR_W
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [NCH-1:0]        chan_mask,
  input  logic [ADDR_W-1:0]     offset,
  input  logic [ADDR_W-1:0]     filesize,
  output logic                  busy,
  output logic                  acc_done,
  output logic [NCH-1:0]        ch_enable,
  output logic                  ram_read_enable,
  output logic                  ram_write_enable,
  output logic [ADDR_W-1:0]     ram_addr,
  input  logic [DATA_W-1:0]     ram_rdata,
  output logic [DATA_W-1:0]     ram_wdata,
  input  logic [NCH-1:0]        to_full,
  output logic [NCH-1:0]        put_req,
  output logic [DATA_W-1:0]     to_data,
  input  logic [NCH-1:0]        from_empty,
  output logic [NCH-1:0]        get_req,
  input  logic [NCH*DATA_W-1:0] from_data
);
  localparam int unsigned IDX_W = (NCH > 1) ? $clog2(NCH) : 1;

  state_t            state;
  logic [NCH-1:0]    mask_r;
  logic [ADDR_W-1:0] fsize_r;
  logic [ADDR_W-1:0] rd_base [NCH];
  logic [ADDR_W-1:0] wr_base [NCH];
  logic [ADDR_W-1:0] rd_cnt  [NCH];
  logic [ADDR_W-1:0] wr_cnt  [NCH];
  logic [IDX_W-1:0]  rr_ptr;
  logic [NCH-1:0]    put_r;
  logic [ADDR_W-1:0] addr_hold;
  logic [DATA_W-1:0] wdata_hold;

  logic [ADDR_W-1:0] nxt_rd_base [NCH];
  logic [ADDR_W-1:0] nxt_wr_base [NCH];
  logic [DATA_W-1:0] from_word   [NCH];
  logic [NCH-1:0]    done, rd_req, wr_req, req, grant;
  logic [IDX_W-1:0]  grant_idx;
  logic              grant_valid, do_wr, do_rd, in_run, all_done;

  assign in_run   = (state == RUN);
  assign all_done = &done;
  assign req      = rd_req | wr_req;

  // Channel bases come from a running sum of 2*filesize, so no multiplier.
  always_comb begin
    logic [ADDR_W-1:0] acc;
    acc = offset;
    for (int unsigned c = 0; c < NCH; c++) begin
      nxt_rd_base[c] = acc;
      nxt_wr_base[c] = acc + filesize;
      acc            = acc + {filesize[ADDR_W-2:0], 1'b0};
    end
  end

  always_comb begin
    done   = '0;
    rd_req = '0;
    wr_req = '0;
    for (int unsigned c = 0; c < NCH; c++) begin
      from_word[c] = from_data[c*DATA_W +: DATA_W];
      done[c]   = !mask_r[c] || (rd_cnt[c] == fsize_r && wr_cnt[c] == fsize_r);
      // A read is never issued back-to-back to one channel, so the push
      // from the previous read is always accounted for in to_full.
      rd_req[c] = in_run && mask_r[c] && (rd_cnt[c] < fsize_r) && !to_full[c] && !put_r[c];
      wr_req[c] = in_run && mask_r[c] && (wr_cnt[c] < fsize_r) && !from_empty[c];
    end
  end

  dc_rr_arbiter #(.N(NCH)) u_arb (
    .req         (req),
    .ptr         (rr_ptr),
    .grant       (grant),
    .grant_idx   (grant_idx),
    .grant_valid (grant_valid)
  );

  assign do_wr = grant_valid && wr_req[grant_idx];
  assign do_rd = grant_valid && !wr_req[grant_idx];

  always_comb begin
    ram_write_enable = do_wr;
    ram_read_enable  = do_rd;
    get_req          = do_wr ? grant : '0;
    ram_addr         = addr_hold;
    ram_wdata        = wdata_hold;
    if (do_wr) begin
      ram_addr  = wr_base[grant_idx] + wr_cnt[grant_idx];
      ram_wdata = from_word[grant_idx];
    end else if (do_rd) begin
      ram_addr  = rd_base[grant_idx] + rd_cnt[grant_idx];
    end
  end

  assign busy      = (state != IDLE);
  assign acc_done  = (state == FIN);
  assign ch_enable = in_run ? (mask_r & ~done) : '0;
  assign put_req   = put_r;
  assign to_data   = (put_r != '0) ? ram_rdata : '0;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      mask_r     <= '0;
      fsize_r    <= '0;
      rr_ptr     <= '0;
      put_r      <= '0;
      addr_hold  <= '0;
      wdata_hold <= '0;
      for (int unsigned c = 0; c < NCH; c++) begin
        rd_base[c] <= '0;
        wr_base[c] <= '0;
        rd_cnt[c]  <= '0;
        wr_cnt[c]  <= '0;
      end
    end else begin
      put_r <= do_rd ? grant : '0;
      if (grant_valid) begin
        addr_hold <= ram_addr;
        rr_ptr    <= IDX_W'(wrap_inc(32'(grant_idx), NCH));
      end
      if (do_wr) begin
        wdata_hold        <= ram_wdata;
        wr_cnt[grant_idx] <= wr_cnt[grant_idx] + 1'b1;
      end
      if (do_rd) rd_cnt[grant_idx] <= rd_cnt[grant_idx] + 1'b1;
      case (state)
        IDLE: if (start) begin
          state   <= RUN;
          mask_r  <= chan_mask;
          fsize_r <= filesize;
          for (int unsigned c = 0; c < NCH; c++) begin
            rd_base[c] <= nxt_rd_base[c];
            wr_base[c] <= nxt_wr_base[c];
            rd_cnt[c]  <= '0;
            wr_cnt[c]  <= '0;
          end
        end
        RUN:     if (all_done) state <= FIN;
        FIN:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
